// File: rtl/bcd_disp_pkg.sv
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared BCD widths/limits and the anode-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_MIN    = 4'd0;
    localparam int         MAX_DIGITS = 8;

    // One-hot active-low select for up to MAX_DIGITS digits.
    function automatic logic [MAX_DIGITS-1:0] anode_from_idx(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// ============================================================================
// Module      : bcd_digit_cell
// Description : One BCD digit register with increment/decrement and ripple
//               carry/borrow, plus synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell
    import bcd_disp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic             up_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        carry_o = 1'b0;
        if (clr_i) begin
            digit_d = BCD_MIN;
        end else if (step_i) begin
            if (up_i) begin
                // >= keeps any out-of-range value funnelled back to 0
                if (digit_q >= BCD_MAX) begin
                    digit_d = BCD_MIN;
                    carry_o = 1'b1;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end else begin
                if (digit_q == BCD_MIN || digit_q > BCD_MAX) begin
                    digit_d = BCD_MAX;
                    carry_o = 1'b1;
                end else begin
                    digit_d = digit_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
// ============================================================================
// Module      : bcd_scan_counter
// Description : Multi-digit BCD up/down counter with a multiplexed display
//               scanner. Define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank
//               leading-zero digit slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_DIV  = 50000,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        up_dn,
    input  logic                        clr,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        carry_out,
    output logic [BCD_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]       anode
);

    localparam int CNT_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_DIV - 1);
    localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]            cnt_q,   cnt_d;
    logic [SCN_W-1:0]            scn_q,   scn_d;
    logic [IDX_W-1:0]            idx_q,   idx_d;
    logic                        carry_q, carry_d;
    logic [BCD_W-1:0]            digit_q, digit_d;
    logic [NUM_DIGITS-1:0]       anode_q, anode_d;

    logic                        w_tick;
    logic [NUM_DIGITS:0]         w_step;
    logic [BCD_W*NUM_DIGITS-1:0] w_count;

    always_comb begin
        w_tick = en && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        end

        scn_d = (scn_q == SCN_LAST) ? '0 : scn_q + 1'b1;
        idx_d = idx_q;
        if (scn_q == SCN_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Ripple chain: step into digit 0 is the tick, the last carry is the wrap.
    assign w_step[0] = w_tick && !clr;
    assign carry_d   = w_step[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr),
            .step_i  (w_step[g]),
            .up_i    (up_dn),
            .digit_o (w_count[g*BCD_W +: BCD_W]),
            .carry_o (w_step[g+1])
        );
    end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    logic w_lz_run;
    logic w_blank;
`endif

    always_comb begin
        digit_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_d = w_count[i*BCD_W +: BCD_W];
            end
        end
        anode_d = NUM_DIGITS'(anode_from_idx(3'(idx_q)));
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        // Walk down from the MSD; digit 0 is never considered for blanking.
        w_lz_run = 1'b1;
        w_blank  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run = w_lz_run && (w_count[i*BCD_W +: BCD_W] == BCD_MIN);
            if (idx_q == IDX_W'(i) && w_lz_run) begin
                w_blank = 1'b1;
            end
        end
        if (w_blank) begin
            anode_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            scn_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            digit_q <= '0;
            anode_q <= NUM_DIGITS'(anode_from_idx(3'd0));
        end else begin
            cnt_q   <= cnt_d;
            scn_q   <= scn_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            digit_q <= digit_d;
            anode_q <= anode_d;
        end
    end

    assign count_bcd = w_count;
    assign carry_out = carry_q;
    assign digit_out = digit_q;
    assign anode     = anode_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
// ============================================================================
// Module      : tb_bcd_scan_counter
// Description : Directed self-checking bench for bcd_scan_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_scan_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic [15:0] count_bcd;
    logic        carry_out;
    logic [3:0]  digit_out;
    logic [3:0]  anode;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_scan_counter #(
        .NUM_DIGITS (4),
        .COUNT_DIV  (1),
        .SCAN_DIV   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up_dn     (up_dn),
        .clr       (clr),
        .count_bcd (count_bcd),
        .carry_out (carry_out),
        .digit_out (digit_out),
        .anode     (anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_ticks(input int n, input logic dir);
        up_dn = dir;
        en    = 1'b1;
        step(n);
        en    = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_an;
        logic       found;
        int         exp_dig [4];
        exp_dig = '{4, 3, 2, 1};

        reset = 1'b1;
        en    = 1'b0;
        up_dn = 1'b1;
        clr   = 1'b0;
        step(3);
        reset = 1'b0;
        check("rst_count", 32'(count_bcd), 32'h0000);
        check("rst_anode", 32'(anode),     32'b1110);
        check("rst_digit", 32'(digit_out), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);

        count_ticks(10, 1'b1);
        check("up10", 32'(count_bcd), 32'h0010);
        count_ticks(1009, 1'b1);
        check("up1019", 32'(count_bcd), 32'h1019);

        count_ticks(8980, 1'b1);
        check("up9999", 32'(count_bcd), 32'h9999);
        check("up9999_carry", 32'(carry_out), 32'd0);
        count_ticks(1, 1'b1);
        check("wrap_up_count", 32'(count_bcd), 32'h0000);
        check("wrap_up_carry", 32'(carry_out), 32'd1);
        step(1);
        check("wrap_up_carry_end", 32'(carry_out), 32'd0);
        check("wrap_up_hold", 32'(count_bcd), 32'h0000);

        count_ticks(1, 1'b0);
        check("wrap_dn_count", 32'(count_bcd), 32'h9999);
        check("wrap_dn_carry", 32'(carry_out), 32'd1);
        step(1);
        check("wrap_dn_carry_end", 32'(carry_out), 32'd0);
        count_ticks(1, 1'b0);
        check("dn9998", 32'(count_bcd), 32'h9998);
        check("dn9998_carry", 32'(carry_out), 32'd0);

        // Scan sequence with count frozen at 1234
        pulse_reset();
        count_ticks(1234, 1'b1);
        check("load1234", 32'(count_bcd), 32'h1234);
        found = 1'b0;
        prev  = anode;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (prev != 4'b1110 && anode == 4'b1110) found = 1'b1;
            prev = anode;
        end
        check("scan_sync", 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                exp_an = ~(4'b0001 << (k / 4));
                check("scan_anode", 32'(anode), 32'(exp_an));
                check("scan_digit", 32'(digit_out), 32'(exp_dig[k / 4]));
                step(1);
            end
        end

        // clr wins over a simultaneous tick
        pulse_reset();
        count_ticks(42, 1'b1);
        check("load0042", 32'(count_bcd), 32'h0042);
        up_dn = 1'b1;
        en    = 1'b1;
        clr   = 1'b1;
        step(1);
        clr   = 1'b0;
        en    = 1'b0;
        check("clr_count", 32'(count_bcd), 32'h0000);
        check("clr_carry", 32'(carry_out), 32'd0);
        step(1);
        check("clr_hold", 32'(count_bcd), 32'h0000);

        // Reset in the middle of the scan returns to index 0
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (anode == 4'b1011) found = 1'b1;
        end
        check("midscan_sync", 32'(found), 32'd1);
        pulse_reset();
        check("midscan_anode", 32'(anode), 32'b1110);
        check("midscan_digit", 32'(digit_out), 32'd0);
        step(4);
        check("midscan_hold", 32'(anode), 32'b1110);
        step(1);
        check("midscan_adv", 32'(anode), 32'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit decimal (BCD) up/down counter with a built-in display scanner.
- Sits directly upstream of the 7-segment LED decoder.
- Each scan slot presents one 4-bit BCD digit on digit_out and the matching active-low digit-select on anode; digit_out drives the decoder's BCD input.
- Guarantees every digit presented is 0-9, so the decoder default branch is never exercised.

Parameters:
- NUM_DIGITS, 4: number of BCD digits (1..8).
- COUNT_DIV, 50000: clock cycles per count tick while en=1 (>=1).
- SCAN_DIV, 1000: clock cycles each digit is held on the display (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; 0 freezes count prescaler and count, scan continues.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clr  in  1  synchronous clear of count value and count prescaler.
- count_bcd  out  4*NUM_DIGITS  full count, digit 0 (least significant) in bits [3:0].
- carry_out  out  1  one-cycle pulse on wrap (9..9->0..0 up, 0..0->9..9 down).
- digit_out  out  4  BCD digit currently scanned, to decoder.
- anode  out  NUM_DIGITS  one-hot active-low digit select aligned with digit_out.

Interface: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset values:
  - count_bcd=0; carry_out=0.
  - Count prescaler=0; scan prescaler=0; scan index=0.
  - digit_out=0; anode = all ones except bit0=0.
- Priority: reset > clr > tick.
  - clr zeroes count and count prescaler, forces carry_out=0, and leaves scan untouched.
- Count prescaler:
  - Increments each cycle with en=1.
  - At COUNT_DIV-1 it wraps to 0 and asserts an internal tick that same cycle.
  - With COUNT_DIV=1, every en cycle is a tick.
- On tick, up (up_dn=1):
  - Digit 0 +1; a digit at 9 becomes 0 and carries into the next digit (ripple in one cycle).
  - All digits 9 -> all 0 and carry_out=1 for exactly the next cycle.
- On tick, down (up_dn=0):
  - Digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
  - All 0 -> all 9 and carry_out=1.
- carry_out is registered, 1 cycle wide, and is 0 on every non-wrap cycle.
- count_bcd updates on the clock edge ending the tick cycle (1-cycle latency from tick).
- Scan:
  - Scan prescaler runs every cycle regardless of en/clr.
  - At SCAN_DIV-1 it wraps and the scan index advances 0,1,..,NUM_DIGITS-1,0.
- Display outputs:
  - digit_out and anode are registered together from the scan index and the current count, so both change on the same edge.
  - digit_out reflects a count change within 1 cycle even mid-slot.
- Exactly one anode bit is low at all times outside the optional blanking.
- Counter digits never leave 0..9, including after reset mid-operation.

Optional Feature:
- Macro: BCD_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - During a slot whose digit is a leading zero (it and all more-significant digits are 0, index>0), anode is driven all ones (blank); digit_out still shows 0.
  - Digit 0 is never blanked.
- Not defined: every slot drives its anode bit low.

Decomposition:
- Package bcd_disp_pkg:
  - BCD_W=4; BCD_MAX=4'd9; BCD_MIN=4'd0.
  - Function for one-hot active-low anode from index.
- Sub-module bcd_digit_cell: one digit register with inc/dec, carry/borrow in and out, clear; instantiated NUM_DIGITS times.
- Top holds prescalers, scan mux and carry_out register.

Test Plan:
Bench parameters: NUM_DIGITS=4, COUNT_DIV=1, SCAN_DIV=4 unless noted.
- reset held 3 cycles, released -> count_bcd=16'h0000, anode=4'b1110, digit_out=0, carry_out=0.
- en=1, up_dn=1 for 10 cycles -> count_bcd=16'h0010; 1009 more -> 16'h1019.
- Load via 9999 up-ticks, then one more -> count_bcd=16'h0000, carry_out high exactly 1 cycle.
- From 0000, en=1, up_dn=0 for 1 cycle -> 16'h9999 with carry_out pulse; next tick -> 16'h9998.
- Count=16'h1234, en=0 -> anode sequence 1110,1101,1011,0111 each held 4 cycles; digit_out 4,3,2,1 aligned.
- clr and tick in the same cycle at 16'h0042 -> 16'h0000, no carry_out; reset mid-scan -> index 0 next cycle.
